// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: op codes, ALU select codes, FSM states
// and the decoded-instruction record produced by alu_sel_decode.
// Combinational definitions only; no latency, no flow control.
package alu_seq_pkg;

    // Decoded instruction op codes; 4'd9..4'd15 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_LW   = 4'd1,
        OP_SW   = 4'd2,
        OP_NOR  = 4'd3,
        OP_NORI = 4'd4,
        OP_NOT  = 4'd5,
        OP_BLEU = 4'd6,
        OP_ROLV = 4'd7,
        OP_RORV = 4'd8
    } op_e;

    // ALU select codes as understood by the ALU block.
    localparam logic [4:0] ALU_SEL_ADD  = 5'b10000;
    localparam logic [4:0] ALU_SEL_LW   = 5'b10001;
    localparam logic [4:0] ALU_SEL_SW   = 5'b10101;
    localparam logic [4:0] ALU_SEL_NOR  = 5'b10011;
    localparam logic [4:0] ALU_SEL_NORI = 5'b00111;
    localparam logic [4:0] ALU_SEL_NOT  = 5'b00010;
    localparam logic [4:0] ALU_SEL_BLEU = 5'b01000;
    localparam logic [4:0] ALU_SEL_ROLV = 5'b00000;
    localparam logic [4:0] ALU_SEL_RORV = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Source of ALU operand 2.
    typedef enum logic [1:0] {
        I2_RT   = 2'd0,
        I2_SEXT = 2'd1,
        I2_ZEXT = 2'd2
    } i2_src_e;

    typedef struct packed {
        logic [4:0] sel;
        i2_src_e    i2_src;
        logic       i1_zero;   // operand 1 forced to zero (NOT)
        logic       is_mem;    // LW or SW: needs a memory phase
        logic       is_store;  // SW
        logic       illegal;   // op code outside op_e
    } dec_t;

endpackage

// File: rtl/alu_sel_decode.sv
// Maps an op code to the ALU select code, operand routing and memory flags.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the sequencer samples it.
// Ports: op (raw 4-bit op code in) -> dec (decoded record out).
module alu_sel_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.i2_src   = I2_RT;
        case (op)
            OP_ADD:  dec.sel = ALU_SEL_ADD;
            OP_LW: begin
                dec.sel    = ALU_SEL_LW;
                dec.i2_src = I2_SEXT;
                dec.is_mem = 1'b1;
            end
            OP_SW: begin
                dec.sel      = ALU_SEL_SW;
                dec.i2_src   = I2_SEXT;
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
            end
            OP_NOR:  dec.sel = ALU_SEL_NOR;
            OP_NORI: begin
                dec.sel    = ALU_SEL_NORI;
                dec.i2_src = I2_ZEXT;
            end
            OP_NOT: begin
                dec.sel     = ALU_SEL_NOT;
                dec.i1_zero = 1'b1;
            end
            OP_BLEU: dec.sel = ALU_SEL_BLEU;
            OP_ROLV: dec.sel = ALU_SEL_ROLV;
            OP_RORV: dec.sel = ALU_SEL_RORV;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle initiator: issues one decoded instruction to the ALU, runs the LW/SW memory phase, returns a response.
// Latency: accept cycle T -> rsp_valid at T+2 (ALU ops), one cycle after mem_ack (LW/SW), T+1 for illegal ops.
// Backpressure: req_ready only in IDLE (no overlap); response held stable until rsp_ready.
// Ports: req_* (instruction in, valid/ready), alu_* (ALU select/operands out, result in),
//        mem_* (single outstanding memory request, 1-cycle ack), rsp_* (response out, valid/ready).
// Build option: define ALU_SEQ_TIMEOUT_EN to abort the memory phase after TIMEOUT_CYCLES ack-less cycles.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int IMM_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_rs,
    input  logic [31:0]      req_rt,
    input  logic [IMM_W-1:0] req_imm,
    output logic [4:0]       alu_sel,
    output logic [31:0]      alu_i1,
    output logic [31:0]      alu_i2,
    input  logic [31:0]      alu_o,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_taken,
    output logic             rsp_err
);

    state_e      state_q, state_d;
    dec_t        dec;

    logic [4:0]  sel_q;
    logic [31:0] i1_q, i2_q, rt_q, res_q;
    logic        is_mem_q, is_store_q, is_bleu_q;
    logic        taken_q, err_q;

    logic [31:0] imm_sext, imm_zext, i2_nxt;
    logic        accept, tmo_expire;

    alu_sel_decode u_dec (
        .op  (req_op),
        .dec (dec)
    );

    assign imm_sext = {{(32-IMM_W){req_imm[IMM_W-1]}}, req_imm};
    assign imm_zext = {{(32-IMM_W){1'b0}}, req_imm};
    assign accept   = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        i2_nxt = req_rt;
        case (dec.i2_src)
            I2_SEXT: i2_nxt = imm_sext;
            I2_ZEXT: i2_nxt = imm_zext;
            default: i2_nxt = req_rt;
        endcase
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts ack-less MEM cycles; EXEC always precedes MEM, so clearing there
    // gives a fresh count on every MEM entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_EXEC) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_MEM && !mem_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // A same-cycle ack takes priority over expiry.
    assign tmo_expire = (state_q == ST_MEM) && !mem_ack &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    // Without the timeout the memory phase waits for mem_ack indefinitely.
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYCLES == 0);
    assign tmo_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = dec.illegal ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = is_mem_q ? ST_MEM : ST_RESP;
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = res_q;
                mem_wdata = rt_q;
                if (mem_ack || tmo_expire) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers. ALU operands are loaded at accept so they are
    // registered and stable for the whole EXEC cycle, and simply hold after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            rt_q       <= '0;
            res_q      <= '0;
            is_mem_q   <= 1'b0;
            is_store_q <= 1'b0;
            is_bleu_q  <= 1'b0;
            taken_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        err_q   <= dec.illegal;
                        taken_q <= 1'b0;
                        if (dec.illegal) begin
                            // No ALU issue: operands and select keep old values.
                            res_q <= '0;
                        end else begin
                            sel_q      <= dec.sel;
                            i1_q       <= dec.i1_zero ? 32'd0 : req_rs;
                            i2_q       <= i2_nxt;
                            rt_q       <= req_rt;
                            is_mem_q   <= dec.is_mem;
                            is_store_q <= dec.is_store;
                            is_bleu_q  <= (req_op == OP_BLEU);
                        end
                    end
                end
                ST_EXEC: begin
                    res_q   <= alu_o;
                    // alu_o = rs - rt for BLEU: negative or zero means rs <= rt.
                    taken_q <= is_bleu_q && (alu_o[31] || (alu_o == 32'd0));
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        // SW keeps the address as its result.
                        if (!is_store_q) res_q <= mem_rdata;
                    end else if (tmo_expire) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_sel    = sel_q;
    assign alu_i1     = i1_q;
    assign alu_i2     = i2_q;
    assign rsp_result = res_q;
    assign rsp_taken  = taken_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_rs = '0;
    logic [31:0] req_rt = '0;
    logic [15:0] req_imm = '0;
    logic [4:0]  alu_sel;
    logic [31:0] alu_i1, alu_i2;
    logic [31:0] alu_o;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_taken, rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.IMM_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_imm    (req_imm),
        .alu_sel    (alu_sel),
        .alu_i1     (alu_i1),
        .alu_i2     (alu_i2),
        .alu_o      (alu_o),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_taken  (rsp_taken),
        .rsp_err    (rsp_err)
    );

    // Combinational ALU that the sequencer drives.
    logic [5:0] amt;
    always_comb begin
        amt   = {3'b000, alu_i1[2:0]};
        alu_o = '0;
        case (alu_sel)
            5'b10000, 5'b10001, 5'b10101: alu_o = alu_i1 + alu_i2;
            5'b10011, 5'b00111:           alu_o = ~(alu_i1 | alu_i2);
            5'b00010:                     alu_o = ~alu_i2;
            5'b01000:                     alu_o = alu_i1 - alu_i2;
            5'b00000: alu_o = (alu_i2 << amt) | (alu_i2 >> (6'd32 - amt));
            5'b00001: alu_o = (alu_i2 >> amt) | (alu_i2 << (6'd32 - amt));
            default:                      alu_o = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a non-memory op, check EXEC operands and the T+2 response, then drain it.
    task automatic run_alu(input string tag, input logic [3:0] op,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic [4:0] esel,
                           input logic [31:0] ei1, input logic [31:0] ei2,
                           input logic [31:0] eres, input logic etaken);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_imm = imm;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " exec sel"},   32'(alu_sel), 32'(esel));
        chk({tag, " exec i1"},    alu_i1, ei1);
        chk({tag, " exec i2"},    alu_i2, ei2);
        chk({tag, " exec ready"}, 32'(req_ready), 32'd0);
        chk({tag, " exec vld"},   32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " rsp vld"},    32'(rsp_valid), 32'd1);
        chk({tag, " rsp result"}, rsp_result, eres);
        chk({tag, " rsp taken"},  32'(rsp_taken), 32'(etaken));
        chk({tag, " rsp err"},    32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle vld"},   32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset state, before any clock edge.
        #2;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mem_req",   32'(mem_req), 32'd0);
        chk("rst alu_sel",   32'(alu_sel), 32'd0);
        chk("rst result",    rsp_result, 32'd0);
        chk("rst err",       32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_alu("ADD",   4'd0, 32'd5, 32'd7, 16'h0000, 5'b10000, 32'd5, 32'd7, 32'd12, 1'b0);
        run_alu("ROLV",  4'd7, 32'd3, 32'h80000001, 16'h0, 5'b00000, 32'd3, 32'h80000001, 32'h0000000C, 1'b0);
        run_alu("RORV",  4'd8, 32'h0F, 32'h80, 16'h0, 5'b00001, 32'h0F, 32'h80, 32'h00000001, 1'b0);
        run_alu("BLEU eq", 4'd6, 32'd4, 32'd4, 16'h0, 5'b01000, 32'd4, 32'd4, 32'h00000000, 1'b1);
        run_alu("BLEU lt", 4'd6, 32'd3, 32'd4, 16'h0, 5'b01000, 32'd3, 32'd4, 32'hFFFFFFFF, 1'b1);
        run_alu("BLEU gt", 4'd6, 32'd5, 32'd4, 16'h0, 5'b01000, 32'd5, 32'd4, 32'h00000001, 1'b0);
        run_alu("NOR",   4'd3, 32'h0F0F0000, 32'h000000FF, 16'h0, 5'b10011, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00, 1'b0);
        run_alu("NORI",  4'd4, 32'h000000F0, 32'h0, 16'h8000, 5'b00111, 32'h000000F0, 32'h00008000, 32'hFFFF7F0F, 1'b0);
        run_alu("NOT",   4'd5, 32'hFFFFFFFF, 32'h12345678, 16'h0, 5'b00010, 32'h0, 32'h12345678, 32'hEDCBA987, 1'b0);

        // LW with sign-extended negative offset, ack on the third MEM cycle.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd1; req_rs = 32'h100; req_rt = 32'h0; req_imm = 16'hFFFC;
        @(negedge clk);
        req_valid = 1'b0;
        chk("LW exec sel", 32'(alu_sel), 32'(5'b10001));
        chk("LW exec i2",  alu_i2, 32'hFFFFFFFC);
        @(negedge clk);
        chk("LW mem_req",  32'(mem_req), 32'd1);
        chk("LW mem_we",   32'(mem_we), 32'd0);
        chk("LW mem_addr", mem_addr, 32'h000000FC);
        chk("LW no rsp",   32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("LW mem_req hold1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("LW mem_req hold2", 32'(mem_req), 32'd1);
        chk("LW addr hold2",    mem_addr, 32'h000000FC);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("LW mem_req drop", 32'(mem_req), 32'd0);
        chk("LW rsp vld",      32'(rsp_valid), 32'd1);
        chk("LW rsp result",   rsp_result, 32'hDEADBEEF);
        chk("LW rsp err",      32'(rsp_err), 32'd0);
        // Consumer stalls for four cycles: response must hold.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("LW stall vld",    32'(rsp_valid), 32'd1);
            chk("LW stall result", rsp_result, 32'hDEADBEEF);
            chk("LW stall ready",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("LW drained", 32'(req_ready), 32'd1);

        // Stray ack in IDLE is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("stray ack ready", 32'(req_ready), 32'd1);
        chk("stray ack vld",   32'(rsp_valid), 32'd0);
        chk("stray ack mreq",  32'(mem_req), 32'd0);

        // SW: immediate ack, result is the address.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd2; req_rs = 32'h200; req_rt = 32'hCAFEF00D; req_imm = 16'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("SW exec sel", 32'(alu_sel), 32'(5'b10101));
        @(negedge clk);
        chk("SW mem_req",   32'(mem_req), 32'd1);
        chk("SW mem_we",    32'(mem_we), 32'd1);
        chk("SW mem_addr",  mem_addr, 32'h00000210);
        chk("SW mem_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("SW rsp vld",    32'(rsp_valid), 32'd1);
        chk("SW rsp result", rsp_result, 32'h00000210);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Illegal op 12: response one cycle after accept, no ALU issue.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd12; req_rs = 32'h1; req_rt = 32'h2; req_imm = 16'h3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ILL rsp vld",    32'(rsp_valid), 32'd1);
        chk("ILL rsp err",    32'(rsp_err), 32'd1);
        chk("ILL rsp result", rsp_result, 32'd0);
        chk("ILL rsp taken",  32'(rsp_taken), 32'd0);
        chk("ILL alu_sel",    32'(alu_sel), 32'(5'b10101));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ILL drained", 32'(req_ready), 32'd1);

        // Reset while in MEM: outputs drop without a clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd1; req_rs = 32'h40; req_rt = 32'h0; req_imm = 16'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("RST pre mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("RST mem_req",   32'(mem_req), 32'd0);
        chk("RST rsp_valid", 32'(rsp_valid), 32'd0);
        chk("RST req_ready", 32'(req_ready), 32'd1);
        chk("RST alu_sel",   32'(alu_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("RST no rsp",   32'(rsp_valid), 32'd0);
        chk("RST no mreq",  32'(mem_req), 32'd0);

        // Recovery after reset, with 32-bit wraparound.
        run_alu("ADD wrap", 4'd0, 32'hFFFFFFFF, 32'd1, 16'h0, 5'b10000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multicycle initiator that drives the ALU's select and operand inputs and consumes its 32-bit result. It accepts one decoded instruction at a time through a valid/ready request port and maps the operation to the 5-bit ALU select code. It drives the ALU operands, captures the ALU output, and for LW/SW completes a memory transaction. Sits between the decode stage and the ALU/data-memory in the datapath.

Parameters:
IMM_W, 16, immediate field width; sign- or zero-extended to 32 bits.
TIMEOUT_CYCLES, 64, memory-ack wait limit; used only when ALU_SEQ_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  instruction offered
req_ready  out  1  sequencer can accept
req_op  in  4  op_e code (package)
req_rs  in  32  Rs value
req_rt  in  32  Rt value
req_imm  in  IMM_W  immediate field
alu_sel  out  5  ALU select code
alu_i1  out  32  ALU operand 1
alu_i2  out  32  ALU operand 2
alu_o  in  32  ALU result, combinational from alu_sel/alu_i1/alu_i2
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  32  memory byte address
mem_wdata  out  32  store data
mem_ack  in  1  memory completion, 1-cycle pulse
mem_rdata  in  32  load data, valid with mem_ack
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  ALU result, or load data for LW
rsp_taken  out  1  BLEU condition, Rs <= Rt
rsp_err  out  1  illegal op, or memory timeout

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - alu_sel = 5'b00000.
- The FSM has four states: IDLE, EXEC, MEM, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid & req_ready, register op, rs, rt, imm and go to EXEC.
  - If the op is illegal, go straight to RESP with rsp_err = 1 and rsp_result = 0; no ALU issue.
- EXEC (exactly 1 cycle):
  - alu_sel/i1/i2 are driven from registered values.
  - alu_o is captured into the result register at the end of the cycle.
  - Next state is MEM for LW/SW, otherwise RESP.
- Select codes and operand mapping:
  - ADD: sel 10000, I1 = rs, I2 = rt.
  - LW: sel 10001, I1 = rs, I2 = sext(imm).
  - SW: sel 10101, I1 = rs, I2 = sext(imm).
  - NOR: sel 10011, I1 = rs, I2 = rt.
  - NORI: sel 00111, I1 = rs, I2 = zext(imm).
  - NOT: sel 00010, I2 = rt, I1 = 0.
  - BLEU: sel 01000, I1 = rs, I2 = rt.
  - ROLV: sel 00000, I1 = rs (only bits [2:0] used as amount), I2 = rt.
  - RORV: sel 00001, same operand mapping as ROLV.
- Outside EXEC, alu_sel/i1/i2 hold their last values; they have no meaning there.
- BLEU: rsp_taken = captured[31] | (captured == 0), computed from alu_o = rs - rt. rsp_taken is 0 for all other ops.
- MEM:
  - mem_req = 1 and mem_addr = captured ALU sum; both held until mem_ack.
  - mem_we = 1 for SW, 0 for LW.
  - mem_wdata = rt.
  - On mem_ack, mem_req drops the same cycle's next edge and the FSM goes to RESP. LW replaces the result with mem_rdata; SW keeps the address as the result.
  - mem_ack outside MEM is ignored.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_taken and rsp_err are held stable until rsp_valid & rsp_ready, then return to IDLE.
  - req_ready = 0 in EXEC, MEM and RESP; there is no overlap between instructions.
- Latency:
  - Non-memory ops: accept at edge T, rsp_valid high from T+2.
  - LW/SW: rsp_valid high one cycle after the mem_ack cycle.
- Reset in any state aborts the op immediately: mem_req and rsp_valid go low, and no response is emitted.
- Arithmetic wraps mod 2^32 (ALU side); the sequencer does no overflow detection.

Optional Feature:
ALU_SEQ_TIMEOUT_EN:
- Defined:
  - A counter clears on MEM entry and increments each MEM cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, the FSM drops mem_req, goes to RESP with rsp_err = 1 and rsp_result = 0.
  - A mem_ack in the same cycle as expiry wins, giving normal completion.
- Undefined: no counter exists; MEM waits indefinitely and rsp_err is raised only for illegal ops.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum: ADD=0, LW, SW, NOR, NORI, NOT, BLEU, ROLV, RORV; values 9-15 are illegal.
  - ALU_SEL_* 5-bit localparams.
  - state_e enum.
- Sub-module alu_sel_decode (combinational): op_e -> {alu_sel, i2_src (rt/sext/zext), i1_zero, is_mem, is_store, illegal}.
- The FSM and registers stay in alu_op_sequencer.

Test Plan:
- ADD rs=5, rt=7, accepted at T:
  - alu_sel = 10000 during EXEC.
  - rsp_valid at T+2 with rsp_result = 12, rsp_taken = 0, rsp_err = 0.
- ROLV rs=3, rt=0x80000001 -> rsp_result = 0x0000000C.
- RORV rs=0x0000000F (amount 7), rt=0x00000080 -> rsp_result = 0x00000001.
- BLEU cases:
  - rs=4, rt=4 -> rsp_taken = 1.
  - rs=3, rt=4 -> rsp_taken = 1.
  - rs=5, rt=4 -> rsp_taken = 0.
- LW rs=0x100, imm=0xFFFC:
  - mem_req = 1, mem_we = 0, mem_addr = 0x000000FC.
  - mem_ack after 3 cycles with rdata = 0xDEADBEEF -> rsp_result = 0xDEADBEEF on the next cycle.
- Holding, illegal op and reset:
  - rsp_ready held low 4 cycles -> response stable, req_ready = 0.
  - Op = 12 -> rsp_err = 1 at T+1, alu_sel unchanged.
  - Reset asserted in MEM -> mem_req = 0 without waiting for a clock edge.
